// File: rtl/inv_shift_rows_stream_if.sv
// Byte-in / state-out stream bundle for the (Inv)ShiftRows loader.
// slave is the block's view, master is the environment's view; fwd exists only with SR_FWD_SEL_EN.
interface inv_shift_rows_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         frame_err;
`ifdef SR_FWD_SEL_EN
  logic         fwd;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, fwd,
    output in_ready, out_valid, out_data, frame_err
  );
  modport master (
    output in_valid, in_data, in_last, out_ready, fwd,
    input  in_ready, out_valid, out_data, frame_err
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );
`endif
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: scatters 16 column-major bytes into place; result valid 1 cycle after byte 15.
// Backpressure: holding register frees the fill buffer; in_ready drops only when both are full. SR_FWD_SEL_EN adds fwd.
module inv_shift_rows_stream (
  input  logic clk,
  input  logic rst_n,
  inv_shift_rows_stream_if.slave bus
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [0:15][7:0] fill_q, fill_d, fill_cur;
  logic [127:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             in_xfer, out_xfer;
  logic [1:0]       row, col, dst_col;
  logic [3:0]       dst;

  assign row = cnt_q[1:0];
  assign col = cnt_q[3:2];

`ifdef SR_FWD_SEL_EN
  logic fwd_q, fwd_d, fwd_sel;
  // Direction is latched on byte 0 and applies to the whole block.
  assign fwd_sel = (cnt_q == 4'd0) ? bus.fwd : fwd_q;
  assign dst_col = fwd_sel ? (col - row) : (col + row);
`else
  assign dst_col = col + row;
`endif

  assign dst = {dst_col, row};

  assign in_xfer  = bus.in_valid & (state_q == FILL);
  assign out_xfer = out_valid_q & bus.out_ready;

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.frame_err = frame_err_q;

  always_comb begin
    fill_cur      = fill_q;
    fill_cur[dst] = bus.in_data;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
`ifdef SR_FWD_SEL_EN
    fwd_d       = fwd_q;
`endif
    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (in_xfer) begin
`ifdef SR_FWD_SEL_EN
          fwd_d = fwd_sel;
`endif
          if (bus.in_last && (cnt_q != 4'd15)) begin
            frame_err_d = 1'b1;
            cnt_d       = 4'd0;
          end else begin
            fill_d = fill_cur;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              frame_err_d = ~bus.in_last;
              // Draining in the same cycle frees the holding register, so no bubble.
              if (!out_valid_q || out_xfer) begin
                out_data_d  = fill_cur;
                out_valid_d = 1'b1;
              end else begin
                state_d = FULL;
              end
            end
          end
        end
      end
      FULL: begin
        if (out_xfer) begin
          out_data_d  = fill_q;
          out_valid_d = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SR_FWD_SEL_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
`ifdef SR_FWD_SEL_EN
      fwd_q       <= fwd_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed bench for inv_shift_rows_stream with a byte-list / result-queue reference model.
module tb_inv_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_shift_rows_stream_if bus ();

  inv_shift_rows_stream dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [127:0] INV_00 = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] INV_10 = 128'h101d1a17_14111e1b_1815121f_1c191613;
  localparam logic [127:0] FWD_00 = 128'h00050a0f_04090e03_080d0207_0c01060b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // State matrix s[r][c] = b[4c+r]; inverse pulls column c-r, forward pulls column c+r.
  function automatic logic [127:0] shift_rows(input logic [7:0] b[$], input bit fwd);
    logic [127:0] res;
    int src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = fwd ? ((c + r) % 4) : ((c - r + 4) % 4);
        res[127 - 8 * (4 * c + r) -: 8] = b[4 * src + r];
      end
    end
    return res;
  endfunction

  logic [7:0]   blk[$];
  logic [127:0] exp_q[$];
  bit           blk_fwd;
  bit           exp_ferr;
  bit           p_in, p_last, p_fwd, p_drain;
  logic [7:0]   p_dat;
  int           n_xfer = 0, n_out = 0, n_ferr = 0, cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      blk.delete();
      exp_q.delete();
      exp_ferr = 0;
      p_in     = 0;
      p_drain  = 0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, '0);
      check("rst_frame_err", bus.frame_err, 1'b0);
    end else begin
      exp_ferr = 0;
      if (p_drain && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (p_in) begin
        if (blk.size() == 0) blk_fwd = p_fwd;
        blk.push_back(p_dat);
        n_xfer++;
        if (blk.size() == 16) begin
          exp_q.push_back(shift_rows(blk, blk_fwd));
          exp_ferr = !p_last;
          blk.delete();
        end else if (p_last) begin
          exp_ferr = 1;
          blk.delete();
        end
      end
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("frame_err", bus.frame_err, exp_ferr);
      if (bus.out_valid && exp_q.size() > 0) check("out_data", bus.out_data, exp_q[0]);
      if (bus.frame_err) n_ferr++;
      p_in    = bus.in_valid & bus.in_ready;
      p_dat   = bus.in_data;
      p_last  = bus.in_last;
      p_drain = bus.out_valid & bus.out_ready;
`ifdef SR_FWD_SEL_EN
      p_fwd   = bus.fwd;
`else
      p_fwd   = 0;
`endif
    end
  end

  task automatic send(input logic [7:0] d, input bit last);
    int t = 0;
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) send(base + i[7:0], i == 15);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tq[$];
    int f0, x0, o0, c0, c1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SR_FWD_SEL_EN
    bus.fwd       = 1'b0;
`endif
    for (int i = 0; i < 16; i++) tq.push_back(i[7:0]);
    check("model_inv_00", shift_rows(tq, 0), INV_00);
    check("model_fwd_00", shift_rows(tq, 1), FWD_00);
    tq.delete();
    for (int i = 16; i < 32; i++) tq.push_back(i[7:0]);
    check("model_inv_10", shift_rows(tq, 0), INV_10);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    wait_cycles(1);

    // Inverse pattern, consumer always ready.
    bus.out_ready = 1'b1;
    send_block(8'h00);
    @(negedge clk);
    check("t1_valid", bus.out_valid, 1'b1);
    check("t1_data", bus.out_data, INV_00);
    check("t1_ferr", bus.frame_err, 1'b0);
    wait_cycles(2);

    // Back-pressure: two blocks queue up, then drain without a gap.
    bus.out_ready = 1'b0;
    send_block(8'h00);
    send_block(8'h10);
    @(negedge clk);
    check("t2_in_ready_low", bus.in_ready, 1'b0);
    check("t2_hold_data", bus.out_data, INV_00);
    wait_cycles(5);
    @(negedge clk);
    check("t2_stable_data", bus.out_data, INV_00);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("t2_first", bus.out_data, INV_00);
    @(negedge clk);
    check("t2_second_valid", bus.out_valid, 1'b1);
    check("t2_second", bus.out_data, INV_10);
    wait_cycles(2);

    // Early in_last discards the partial block.
    f0 = n_ferr;
    for (int i = 0; i < 6; i++) send(i[7:0], i == 5);
    wait_cycles(3);
    check("t3_ferr_pulses", n_ferr - f0, 1);
    check("t3_no_output", bus.out_valid, 1'b0);
    send_block(8'h00);
    @(negedge clk);
    check("t3_clean_data", bus.out_data, INV_00);
    wait_cycles(2);

    // Missing in_last on byte 15: error pulse but block still emitted.
    for (int i = 0; i < 16; i++) send(i[7:0], 1'b0);
    @(negedge clk);
    check("t3b_ferr", bus.frame_err, 1'b1);
    check("t3b_data", bus.out_data, INV_00);
    wait_cycles(2);

    // Reset mid-block.
    for (int i = 0; i < 7; i++) send(8'h20 + i[7:0], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_valid", bus.out_valid, 1'b0);
    check("t4_rst_data", bus.out_data, '0);
    wait_cycles(2);
    rst_n = 1'b1;
    send_block(8'h00);
    @(negedge clk);
    check("t4_after_rst", bus.out_data, INV_00);
    wait_cycles(2);

    // Full throughput: 4 blocks back to back.
    x0 = n_xfer;
    o0 = n_out;
    c0 = cyc;
    for (int b = 0; b < 4; b++) send_block(8'(b * 16));
    c1 = cyc;
    wait_cycles(3);
    check("t5_cycles", c1 - c0, 64);
    check("t5_xfers", n_xfer - x0, 64);
    check("t5_outputs", n_out - o0, 4);

`ifdef SR_FWD_SEL_EN
    // Forward mode, fwd dropped after byte 0 must not affect the block.
    bus.fwd = 1'b1;
    send(8'h00, 1'b0);
    bus.fwd = 1'b0;
    for (int i = 1; i < 16; i++) send(i[7:0], i == 15);
    @(negedge clk);
    check("t6_fwd", bus.out_data, FWD_00);
    wait_cycles(2);
    send_block(8'h00);
    @(negedge clk);
    check("t6_inv_again", bus.out_data, INV_00);
    wait_cycles(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
- Byte-serial AES InvShiftRows stage for the decrypt datapath; the inverse of the combinational forward ShiftRows used on the encrypt side.
- Accepts a 16-byte state one byte per handshake in column-major order, scatters each byte directly to its inverse-shifted position, and presents the finished 128-bit state on a valid/ready output.
- An output holding register lets the next block stream in while the previous result waits for the consumer.

Parameters:
- none; the state width is fixed at 128 bits and 16 bytes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block accepts a byte this cycle
- in_data  input  8  state byte k; k=0 is the first byte, maps to state[127:120]
- in_last  input  1  marks byte 15 of a block
- out_valid  output  1  out_data holds a completed state
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  InvShiftRows(block), byte j at [127-8j -: 8]
- frame_err  output  1  one-cycle pulse when a framing error is detected

Behaviour:
- Byte indexing: k = 4c + r (row r = k%4, column c = k/4).
- Inverse mapping: out[r][(c+r)%4] = in[r][c]. Byte k is written to fill-buffer index 4*((c+r)%4)+r.
- Input transfer occurs when in_valid & in_ready. A 4-bit counter cnt advances by 1 per transfer and wraps 15->0.
- States:
  - FILL: in_ready=1. On the cnt==15 transfer: if the holding register is empty, or out_valid & out_ready in the same cycle, copy the fill buffer (including the current byte) to out_data, set out_valid the next cycle, and stay in FILL. Otherwise go to FULL.
  - FULL: in_ready=0. When the holding register frees (out_valid & out_ready), move the fill buffer to out_data and return to FILL; out_valid stays high continuously across the swap.
- Latency: out_valid rises the cycle after the 16th byte is accepted, given an empty holding register.
- out_data/out_valid are stable while out_valid=1 and out_ready=0.
- in_last framing:
  - in_last=1 with cnt!=15: pulse frame_err, discard the partial block, reset cnt to 0, emit nothing.
  - in_last=0 with cnt==15: pulse frame_err, but the block is still completed and emitted.
- Simultaneous completion of an input block and an output drain is lossless with no bubble.
- Reset (async, any time, including mid-block): cnt=0, state=FILL, out_valid=0, out_data=0, frame_err=0, fill buffer=0. in_ready=1 from the first clock after rst_n deasserts. Partial data is lost.
- in_ready depends only on state (registered); there is no combinational path from out_ready to in_ready.

Optional Feature:
- Macro SR_FWD_SEL_EN.
- Defined:
  - Adds input port fwd (1 bit), sampled on the byte k=0 transfer and held for the whole block.
  - fwd=1 selects forward ShiftRows: destination index 4*((c-r)%4)+r, so the same block serves encrypt-side serial loading.
  - fwd=0 selects InvShiftRows.
- Undefined: no fwd port; inverse mapping only.

Test Plan:
- Inverse pattern: reset, stream bytes 0x00..0x0F (in_last on 0x0F), out_ready=1 -> out_valid the cycle after the last byte, out_data=0x000d0a07_04010e0b_0805020f_0c090603, frame_err=0.
- Back-pressure: out_ready=0, stream two blocks (0x00..0x0F, then 0x10..0x1F) -> first result held stable; in_ready=0 after the 32nd byte. Raise out_ready -> first result, then 0x101d1a17_14111e1b_1815121f_1c191613 with no gap in out_valid.
- Framing: in_last on byte 5 -> frame_err pulses once, no output. Next 16 clean bytes 0x00..0x0F -> the inverse-pattern result.
- Reset mid-block: assert rst_n=0 after 7 bytes -> out_valid=0, out_data=0. Full block after release -> correct result; the stale 7 bytes do not appear.
- Throughput: in_valid=1 and out_ready=1 continuously for 4 blocks -> 64 bytes accepted in 64 cycles, 4 outputs each one cycle after their last byte.
- With SR_FWD_SEL_EN and fwd=1: bytes 0x00..0x0F -> out_data=0x00050a0f_04090e03_080d0207_0c01060b, matching combinational ShiftRows.
